uart_rx: RTL and testbench



---
 rtl/uart_rx.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// Purpose     : 8N1 UART receiver with centre-of-bit sampling and a single valid/ready output register.
// Latency     : byte appears on data/data_valid CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after start edge.
// Backpressure: one-entry holding register; a byte completing while it is still full is dropped and flagged on overrun.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active-low
//   rx          serial line, already synchronised to clk, idle high
//   data        received byte, stable while data_valid is high
//   data_valid  byte available, held until accepted
//   data_ready  consumer accepts byte on a clock edge where data_valid & data_ready
//   frame_err   one-cycle pulse: stop bit sampled low (frame discarded)
//   overrun     one-cycle pulse: byte completed while holding register full (byte dropped)
//   busy        receiver is anywhere but idle
module uart_rx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    // Below four clocks per bit the half-bit offset collapses and the
    // centre sample is no longer meaningfully away from the edges.
    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_clks_per_bit
            $error("uart_rx: CLKS_PER_BIT must be >= 4");
        end
    endgenerate

    localparam int H  = CLKS_PER_BIT / 2;
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_HALF = CW'(H - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);
    localparam logic [IW-1:0] IDX_ZERO = '0;
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    logic [CW-1:0]        r_cnt;
    logic [IW-1:0]        r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_ovr;
    logic                 r_busy;

    logic w_cnt_half;
    logic w_cnt_last;
    logic w_byte_done;
    logic w_accept;
    logic w_load;

    assign w_cnt_half  = (r_cnt == CNT_HALF);
    assign w_cnt_last  = (r_cnt == CNT_LAST);
    // A good stop bit completes the byte; r_shift already holds all payload bits.
    assign w_byte_done = (r_state == S_STOP) && w_cnt_last && rx;
    assign w_accept    = r_valid && data_ready;
    // The register can take the new byte if it is empty or being drained on this same edge.
    assign w_load      = w_byte_done && (!r_valid || data_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= CNT_ZERO;
            r_idx   <= IDX_ZERO;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            // Status flags are single-cycle pulses unless re-asserted below.
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!rx) begin
                        r_state <= S_START;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (w_cnt_half) begin
                        if (!rx) begin
                            // Still low at mid start bit: a real frame.
                            r_state <= S_DATA;
                            r_cnt   <= CNT_ZERO;
                            r_idx   <= IDX_ZERO;
                        end else begin
                            // Line went back high: glitch, no output.
                            r_state <= S_IDLE;
                            r_cnt   <= CNT_ZERO;
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_DATA: begin
                    if (w_cnt_last) begin
                        // LSB arrives first, so shift in from the top.
                        r_shift <= {rx, r_shift[DATA_BITS-1:1]};
                        r_cnt   <= CNT_ZERO;
                        if (r_idx == IDX_LAST) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + IDX_ONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_STOP: begin
                    if (w_cnt_last) begin
                        r_cnt <= CNT_ZERO;
                        if (rx) begin
                            // Re-arm mid stop bit so a back-to-back start edge is not missed.
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_BREAK;
                            r_ferr  <= 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end

                S_BREAK: begin
                    // Wait for the line to return high so a held-low line
                    // cannot be mistaken for a stream of start bits.
                    if (rx) begin
                        r_state <= S_IDLE;
                        r_cnt   <= CNT_ZERO;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= CNT_ZERO;
                    r_busy  <= 1'b0;
                end
            endcase

            // Holding register. A completing byte takes priority over a plain
            // handshake; a load on an accepting edge keeps data_valid high.
            if (w_load) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (w_byte_done) begin
                r_ovr <= 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data       = r_data;
    assign data_valid = r_valid;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Purpose     : directed scoreboard bench for uart_rx at default parameters.
// Latency     : checks exact output cycle of completed bytes and error pulses.
// Backpressure: exercises held data, overrun drop and accept-on-completion.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx;
    logic       data_ready;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int n_ferr = 0;
    int n_ovr  = 0;
    logic [7:0] sb[$];

    int f0;
    int o0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(16), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one frame starting on the current negedge, 16 cycles per bit.
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int extra_low);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        rx = stop_bit;
        repeat (16) @(negedge clk);
        if (!stop_bit) repeat (extra_low) @(negedge clk);
        rx = 1'b1;
    endtask

    // Output monitor: sampled shortly after each negedge, once inputs for the
    // coming posedge are settled. Each valid&ready seen is one accepted byte.
    always begin
        @(negedge clk);
        #2;
        if (rst_n === 1'b1) begin
            if (frame_err === 1'b1) n_ferr++;
            if (overrun === 1'b1) n_ovr++;
            if (frame_err === 1'b1 || overrun === 1'b1)
                chk("ferr_ovr_exclusive", {31'd0, frame_err & overrun}, 32'd0);
            if (data_valid === 1'b1 && data_ready === 1'b1) begin
                if (sb.size() == 0) chk("sb_unexpected_byte", {24'd0, data}, 32'hFFFF_FFFF);
                else                chk("sb_data", {24'd0, data}, {24'd0, sb.pop_front()});
            end
        end
    end

    initial begin
        rst_n      = 1'b0;
        rx         = 1'b1;
        data_ready = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset_data",  {24'd0, data}, 32'd0);
        chk("reset_valid", {31'd0, data_valid}, 32'd0);
        chk("reset_busy",  {31'd0, busy}, 32'd0);
        chk("reset_ferr",  {31'd0, frame_err}, 32'd0);
        chk("reset_ovr",   {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 1: 0xA5, ready high, exact latency T0+153.
        data_ready = 1'b1;
        sb.push_back(8'hA5);
        fork drive_frame(8'hA5, 1'b1, 0); join_none
        repeat (152) @(posedge clk);
        @(negedge clk);
        chk("t1_valid_early", {31'd0, data_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("t1_valid", {31'd0, data_valid}, 32'd1);
        chk("t1_data", {24'd0, data}, 32'hA5);
        @(posedge clk); @(negedge clk);
        chk("t1_valid_drop", {31'd0, data_valid}, 32'd0);
        repeat (20) @(negedge clk);
        chk("t1_no_ferr", n_ferr, 32'd0);
        chk("t1_no_ovr", n_ovr, 32'd0);

        // 2: 4-cycle low glitch, back to idle after the mid-start sample.
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("t2_busy_mid", {31'd0, busy}, 32'd1);
        @(posedge clk); @(negedge clk);
        chk("t2_busy_idle", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
        chk("t2_valid", {31'd0, data_valid}, 32'd0);
        chk("t2_no_ferr", n_ferr, 32'd0);

        // 3: bad stop bit then line held low, then a good 0x11 frame.
        f0 = n_ferr;
        fork drive_frame(8'h3C, 1'b0, 40); join_none
        repeat (152) @(posedge clk);
        @(negedge clk);
        chk("t3_ferr_early", {31'd0, frame_err}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("t3_ferr_pulse", {31'd0, frame_err}, 32'd1);
        chk("t3_valid", {31'd0, data_valid}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("t3_ferr_drop", {31'd0, frame_err}, 32'd0);
        repeat (30) @(negedge clk);
        chk("t3_break_busy", {31'd0, busy}, 32'd1);
        repeat (25) @(negedge clk);
        chk("t3_break_exit", {31'd0, busy}, 32'd0);
        chk("t3_ferr_count", n_ferr - f0, 32'd1);
        chk("t3_valid_after", {31'd0, data_valid}, 32'd0);
        sb.push_back(8'h11);
        fork drive_frame(8'h11, 1'b1, 0); join_none
        repeat (170) @(negedge clk);
        chk("t3_sb_drained", sb.size(), 32'd0);

        // 4: ready low, back-to-back 0x01 / 0x02; second byte overruns.
        data_ready = 1'b0;
        o0 = n_ovr;
        sb.push_back(8'h01);
        fork
            begin
                drive_frame(8'h01, 1'b1, 0);
                drive_frame(8'h02, 1'b1, 0);
            end
        join_none
        repeat (330) @(negedge clk);
        chk("t4_ovr_count", n_ovr - o0, 32'd1);
        chk("t4_data_held", {24'd0, data}, 32'h01);
        chk("t4_valid_held", {31'd0, data_valid}, 32'd1);
        data_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t4_valid_clear", {31'd0, data_valid}, 32'd0);
        chk("t4_data_kept", {24'd0, data}, 32'h01);
        chk("t4_sb_drained", sb.size(), 32'd0);

        // 5: 0x55 held, ready rises on the completion cycle of 0xAA.
        data_ready = 1'b0;
        o0 = n_ovr;
        sb.push_back(8'h55);
        sb.push_back(8'hAA);
        fork drive_frame(8'h55, 1'b1, 0); join_none
        repeat (165) @(negedge clk);
        chk("t5_first_valid", {31'd0, data_valid}, 32'd1);
        chk("t5_first_data", {24'd0, data}, 32'h55);
        fork drive_frame(8'hAA, 1'b1, 0); join_none
        repeat (152) @(posedge clk);
        @(negedge clk);
        chk("t5_pre_data", {24'd0, data}, 32'h55);
        data_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("t5_data", {24'd0, data}, 32'hAA);
        chk("t5_valid", {31'd0, data_valid}, 32'd1);
        chk("t5_ovr_pin", {31'd0, overrun}, 32'd0);
        @(posedge clk); @(negedge clk);
        chk("t5_valid_drop", {31'd0, data_valid}, 32'd0);
        repeat (10) @(negedge clk);
        chk("t5_ovr_count", n_ovr - o0, 32'd0);
        chk("t5_sb_drained", sb.size(), 32'd0);

        // 6: reset pulse during bit 4, then a full 0xF0 frame.
        f0 = n_ferr;
        o0 = n_ovr;
        fork drive_frame(8'hF0, 1'b1, 0); join_none
        repeat (84) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t6_rst_data", {24'd0, data}, 32'd0);
        chk("t6_rst_valid", {31'd0, data_valid}, 32'd0);
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("t6_rst_ovr", {31'd0, overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (90) @(negedge clk);
        chk("t6_idle_after", {31'd0, busy}, 32'd0);
        chk("t6_no_ferr", n_ferr - f0, 32'd0);
        chk("t6_no_ovr", n_ovr - o0, 32'd0);
        chk("t6_no_valid", {31'd0, data_valid}, 32'd0);
        sb.push_back(8'hF0);
        fork drive_frame(8'hF0, 1'b1, 0); join_none
        repeat (152) @(posedge clk);
        @(posedge clk); @(negedge clk);
        chk("t6_data", {24'd0, data}, 32'hF0);
        repeat (20) @(negedge clk);
        chk("t6_sb_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
